exe_div_unit: RTL and testbench

Iterative RV64M divide unit in the EXE stage. It consumes the operands and decoded op held by the ID/EXE pipeline register and drives the stall back into that register and upstream stages while a division runs. It supports DIV, DIVU, REM and REMU plus the W variants, using a radix-2 restoring algorithm with one quotient bit per cycle. Special cases (divide-by-zero, signed overflow) complete without iterating.

---
 rtl/exe_div_if.sv | 29 ++
 rtl/exe_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_exe_div_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_div_if.sv
// EXE-stage divide unit bus: operands/decoded op in, stall and result out.
// The master side is the pipeline, the slave side is the divider.
interface exe_div_if #(
    parameter int unsigned XLEN = 64
);
    logic            flush;
    logic            switch_mode;
    logic            valid_exe;
    logic            is_div_exe;
    logic            is_word_exe;
    logic [2:0]      funct3_exe;
    logic [XLEN-1:0] rs1_data_exe;
    logic [XLEN-1:0] rs2_data_exe;
    logic            stall_div;
    logic [XLEN-1:0] div_result;
    logic            div_result_valid;

    modport master (
        output flush, switch_mode, valid_exe, is_div_exe, is_word_exe,
               funct3_exe, rs1_data_exe, rs2_data_exe,
        input  stall_div, div_result, div_result_valid
    );

    modport slave (
        input  flush, switch_mode, valid_exe, is_div_exe, is_word_exe,
               funct3_exe, rs1_data_exe, rs2_data_exe,
        output stall_div, div_result, div_result_valid
    );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring RV64M divider (DIV/DIVU/REM/REMU and W forms).
// One quotient bit per cycle; divide-by-zero and signed overflow skip iteration.
module exe_div_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic     clk,
    input  logic     rst,
    exe_div_if.slave exe
);
    localparam int unsigned HALF  = XLEN / 2;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_is_rem;
    logic             r_is_word;
    logic [XLEN-1:0]  r_result;

    logic             w_kill;
    logic             w_start;
    logic             w_word;
    logic             w_signed;
    logic             w_is_rem;
    logic [XLEN-1:0]  w_a_op;
    logic [XLEN-1:0]  w_b_op;
    logic [XLEN-1:0]  w_a_sx;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_res;

    logic [XLEN:0]    w_rem_sh;
    logic [XLEN:0]    w_sub;
    logic             w_ge;
    logic [XLEN-1:0]  w_rem_nx;
    logic [XLEN-1:0]  w_quo_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_n;
    logic             w_last;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_r_fix;
    logic [XLEN-1:0]  w_sel;
    logic [XLEN-1:0]  w_final;
    logic             w_unused_f3;

    assign w_kill      = exe.flush | exe.switch_mode;
    assign w_start     = exe.valid_exe & exe.is_div_exe & ~w_kill & (r_state == S_IDLE);
    assign w_word      = exe.is_word_exe;
    assign w_signed    = ~exe.funct3_exe[0];
    assign w_is_rem    = exe.funct3_exe[1];
    assign w_unused_f3 = exe.funct3_exe[2];

    // Operand preparation for the start cycle: width select, sign and magnitude.
    always_comb begin
        w_a_op = exe.rs1_data_exe;
        w_b_op = exe.rs2_data_exe;
        w_a_sx = exe.rs1_data_exe;
        if (w_word) begin
            w_a_op = {{HALF{w_signed & exe.rs1_data_exe[HALF-1]}}, exe.rs1_data_exe[HALF-1:0]};
            w_b_op = {{HALF{w_signed & exe.rs2_data_exe[HALF-1]}}, exe.rs2_data_exe[HALF-1:0]};
            w_a_sx = {{HALF{exe.rs1_data_exe[HALF-1]}}, exe.rs1_data_exe[HALF-1:0]};
        end
        w_a_neg    = w_signed & w_a_op[XLEN-1];
        w_b_neg    = w_signed & w_b_op[XLEN-1];
        w_a_abs    = w_a_neg ? (~w_a_op + XLEN'(1)) : w_a_op;
        w_b_abs    = w_b_neg ? (~w_b_op + XLEN'(1)) : w_b_op;
        w_div_zero = (w_b_op == '0);
        w_ovf      = w_signed & (w_b_op == '1) &
                     (w_word ? (exe.rs1_data_exe[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                             : (exe.rs1_data_exe == {1'b1, {(XLEN-1){1'b0}}}));
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero) begin
            w_special_res = w_is_rem ? w_a_sx : '1;
        end else begin
            w_special_res = w_is_rem ? '0 : w_a_sx;
        end
    end

    // One restoring step; the borrow out of the wide subtract is the compare.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[XLEN-1]};
        w_sub    = w_rem_sh - {1'b0, r_div};
        w_ge     = ~w_sub[XLEN];
        w_rem_nx = w_ge ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_ge};
        w_cnt_nx = r_cnt + CNT_W'(1);
        w_n      = r_is_word ? CNT_W'(HALF) : CNT_W'(XLEN);
        w_last   = (w_cnt_nx == w_n);
        w_q_fix  = r_q_neg ? (~w_quo_nx + XLEN'(1)) : w_quo_nx;
        w_r_fix  = r_r_neg ? (~w_rem_nx + XLEN'(1)) : w_rem_nx;
        w_sel    = r_is_rem ? w_r_fix : w_q_fix;
        w_final  = r_is_word ? {{HALF{w_sel[HALF-1]}}, w_sel[HALF-1:0]} : w_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_kill) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (w_last)  w_state_next = S_DONE;
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Stall and result pulse are combinational so a kill takes effect in its own cycle.
    always_comb begin
        exe.stall_div        = 1'b0;
        exe.div_result_valid = 1'b0;
        if (!rst && !w_kill) begin
            exe.stall_div        = w_start | (r_state == S_CALC);
            exe.div_result_valid = (r_state == S_DONE);
        end
    end

    assign exe.div_result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_is_word <= 1'b0;
            r_result  <= '0;
        end else if (w_kill) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_rem     <= '0;
            r_quo     <= w_word ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
            r_div     <= w_b_abs;
            r_cnt     <= '0;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_is_rem  <= w_is_rem;
            r_is_word <= w_word;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= w_cnt_nx;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end
endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed cases, kills, reset and
// randomized ops against an arithmetic reference model.
module tb_exe_div_unit;
    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exe_div_if #(.XLEN(XLEN)) dif ();

    exe_div_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .exe (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Architectural result of an RV64M divide/remainder op.
    function automatic logic [63:0] ref_res(input logic [2:0] f3, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
        bit          sgn;
        bit          rem;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic [63:0] r64;
        sgn = !f3[0];
        rem = f3[1];
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0)                                              r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
            else if (sgn && rem)                                           r32 = $signed(a32) % $signed(b32);
            else if (sgn)                                                  r32 = $signed(a32) / $signed(b32);
            else if (rem)                                                  r32 = a32 % b32;
            else                                                           r32 = a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                                         r64 = rem ? a : '1;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = rem ? 64'd0 : a;
        else if (sgn && rem)                                                    r64 = $signed(a) % $signed(b);
        else if (sgn)                                                           r64 = $signed(a) / $signed(b);
        else if (rem)                                                           r64 = a % b;
        else                                                                    r64 = a / b;
        return r64;
    endfunction

    // Expected number of stalled cycles: 1 for special cases, else N+1.
    function automatic int ref_stall(input logic [2:0] f3, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
        bit sgn;
        sgn = !f3[0];
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    task automatic drive_idle();
        dif.flush        = 1'b0;
        dif.switch_mode  = 1'b0;
        dif.valid_exe    = 1'b0;
        dif.is_div_exe   = 1'b0;
        dif.is_word_exe  = 1'b0;
        dif.funct3_exe   = 3'd0;
        dif.rs1_data_exe = '0;
        dif.rs2_data_exe = '0;
    endtask

    task automatic drive_op(input logic [2:0] f3, input bit w,
                            input logic [63:0] a, input logic [63:0] b);
        dif.flush        = 1'b0;
        dif.switch_mode  = 1'b0;
        dif.valid_exe    = 1'b1;
        dif.is_div_exe   = 1'b1;
        dif.is_word_exe  = w;
        dif.funct3_exe   = f3;
        dif.rs1_data_exe = a;
        dif.rs2_data_exe = b;
    endtask

    // Present one op in EXE and hold it until stall drops (DONE cycle).
    task automatic run_op(input logic [2:0] f3, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          output int n_stall, output int n_valid, output logic [63:0] res);
        n_stall = 0;
        n_valid = 0;
        res     = 'x;
        @(negedge clk);
        drive_op(f3, w, a, b);
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (dif.stall_div) n_stall++;
            if (dif.div_result_valid) begin
                n_valid++;
                res = dif.div_result;
            end
            if (!dif.stall_div) break;
        end
    endtask

    task automatic idle_cycle(output logic stall, output logic valid);
        @(negedge clk);
        drive_idle();
        #1;
        stall = dif.stall_div;
        valid = dif.div_result_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_op(3'b100, 1'b0, 64'd100, 64'd7);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (dif.stall_div !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got=%b exp=0", dif.stall_div);
        end
        n_checks++;
        if (dif.div_result_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=0", dif.div_result_valid);
        end
        n_checks++;
        if (dif.div_result !== 64'd0) begin
            n_fail++; $display("FAIL reset_result got=%h exp=0", dif.div_result);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_non_div();
        int bad;
        logic s, v;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_op(3'b100, c[0], 64'd100, 64'd7);
            dif.is_div_exe = 1'b0;
            #1;
            if (dif.stall_div !== 1'b0 || dif.div_result_valid !== 1'b0) bad++;
        end
        idle_cycle(s, v);
        n_checks++;
        if (bad != 0 || v !== 1'b0) begin
            n_fail++; $display("FAIL non_div_stall got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_unsigned();
        int ns, nv;
        logic [63:0] r;
        logic s, v;
        run_op(3'b101, 1'b0, 64'd100, 64'd7, ns, nv, r);
        n_checks++;
        if (ns !== 65) begin n_fail++; $display("FAIL divu_stall got=%0d exp=65", ns); end
        n_checks++;
        if (nv !== 1 || r !== 64'd14) begin
            n_fail++; $display("FAIL divu_result got=%h pulses=%0d exp=%h", r, nv, 64'd14);
        end
        idle_cycle(s, v);
        n_checks++;
        if (v !== 1'b0 || dif.div_result !== 64'd14) begin
            n_fail++; $display("FAIL divu_hold got=%h valid=%b exp=%h", dif.div_result, v, 64'd14);
        end
        run_op(3'b111, 1'b0, 64'd100, 64'd7, ns, nv, r);
        n_checks++;
        if (ns !== 65 || nv !== 1 || r !== 64'd2) begin
            n_fail++; $display("FAIL remu got=%h stall=%0d pulses=%0d exp=%h", r, ns, nv, 64'd2);
        end
    endtask

    task automatic test_signed();
        int ns, nv;
        logic [63:0] r;
        run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ns, nv, r);
        n_checks++;
        if (ns !== 65 || nv !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL rem_neg got=%h stall=%0d exp=ffffffffffffffff", r, ns);
        end
        run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ns, nv, r);
        n_checks++;
        if (ns !== 65 || nv !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++; $display("FAIL div_neg got=%h stall=%0d exp=fffffffffffffffd", r, ns);
        end
    endtask

    task automatic test_special();
        int ns, nv;
        logic [63:0] r;
        run_op(3'b100, 1'b0, 64'd5, 64'd0, ns, nv, r);
        n_checks++;
        if (ns !== 1 || nv !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL div_by_zero got=%h stall=%0d exp=ffffffffffffffff stall 1", r, ns);
        end
        run_op(3'b110, 1'b0, 64'd5, 64'd0, ns, nv, r);
        n_checks++;
        if (ns !== 1 || nv !== 1 || r !== 64'd5) begin
            n_fail++; $display("FAIL rem_by_zero got=%h stall=%0d exp=5 stall 1", r, ns);
        end
        run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, ns, nv, r);
        n_checks++;
        if (ns !== 1 || nv !== 1 || r !== 64'h8000_0000_0000_0000) begin
            n_fail++; $display("FAIL div_ovf got=%h stall=%0d exp=8000000000000000 stall 1", r, ns);
        end
        run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, ns, nv, r);
        n_checks++;
        if (ns !== 1 || nv !== 1 || r !== 64'd0) begin
            n_fail++; $display("FAIL rem_ovf got=%h stall=%0d exp=0 stall 1", r, ns);
        end
    endtask

    task automatic test_word();
        int ns, nv;
        logic [63:0] r;
        run_op(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ns, nv, r);
        n_checks++;
        if (ns !== 33) begin n_fail++; $display("FAIL divw_stall got=%0d exp=33", ns); end
        n_checks++;
        if (nv !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++; $display("FAIL divw_result got=%h exp=fffffffffffffffd", r);
        end
        run_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, ns, nv, r);
        n_checks++;
        if (ns !== 33 || nv !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++; $display("FAIL divuw got=%h stall=%0d exp=fffffffffffffffe", r, ns);
        end
    endtask

    task automatic test_flush();
        int ns, nv, bad;
        logic [63:0] r;
        logic s, v;
        bad = 0;
        @(negedge clk);
        drive_op(3'b101, 1'b0, 64'd100, 64'd7);
        #1;
        if (dif.stall_div !== 1'b1) bad++;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (dif.stall_div !== 1'b1 || dif.div_result_valid !== 1'b0) bad++;
        end
        @(negedge clk);
        dif.flush = 1'b1;
        #1;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL pre_flush_stall got=%0d bad cycles exp=0", bad); end
        n_checks++;
        if (dif.stall_div !== 1'b0 || dif.div_result_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle stall=%b valid=%b exp=0 0", dif.stall_div, dif.div_result_valid);
        end
        run_op(3'b101, 1'b0, 64'd9, 64'd3, ns, nv, r);
        n_checks++;
        if (ns !== 65 || nv !== 1 || r !== 64'd3) begin
            n_fail++; $display("FAIL after_flush got=%h stall=%0d pulses=%0d exp=3 65 1", r, ns, nv);
        end
        // Kill by privilege switch partway through a W op.
        @(negedge clk);
        drive_op(3'b101, 1'b1, 64'd1000, 64'd10);
        repeat (3) @(negedge clk);
        dif.switch_mode = 1'b1;
        #1;
        n_checks++;
        if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL switch_stall got=%b exp=0", dif.stall_div); end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            idle_cycle(s, v);
            if (s !== 1'b0 || v !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL switch_no_pulse got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        int ns, nv;
        logic [63:0] r;
        @(negedge clk);
        drive_op(3'b100, 1'b0, 64'd1000, 64'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%b exp=0", dif.stall_div); end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if (dif.stall_div !== 1'b0 || dif.div_result_valid !== 1'b0 || dif.div_result !== 64'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs stall=%b valid=%b result=%h exp=0 0 0",
                               dif.stall_div, dif.div_result_valid, dif.div_result);
        end
        run_op(3'b101, 1'b0, 64'd9, 64'd3, ns, nv, r);
        n_checks++;
        if (ns !== 65 || nv !== 1 || r !== 64'd3) begin
            n_fail++; $display("FAIL after_rst got=%h stall=%0d exp=3 65", r, ns);
        end
    endtask

    task automatic test_back_to_back();
        int ns1, nv1, ns2, nv2, extra;
        logic [63:0] r1, r2;
        logic s, v;
        run_op(3'b100, 1'b0, 64'd20, 64'd4, ns1, nv1, r1);
        run_op(3'b100, 1'b0, 64'd21, 64'd4, ns2, nv2, r2);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            idle_cycle(s, v);
            if (v === 1'b1 || s === 1'b1) extra++;
        end
        n_checks++;
        if (nv1 + nv2 + extra !== 2) begin
            n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", nv1 + nv2 + extra);
        end
        n_checks++;
        if (r1 !== 64'd5 || r2 !== 64'd5 || ns1 !== 65 || ns2 !== 65) begin
            n_fail++; $display("FAIL b2b_results got=%h,%h stall=%0d,%0d exp=5,5 65,65", r1, r2, ns1, ns2);
        end
    endtask

    task automatic test_random();
        int ns, nv, kind;
        logic [63:0] a, b, r, exp_r;
        logic [2:0]  f3;
        bit          w;
        logic        s, v;
        for (int i = 0; i < 40; i++) begin
            f3   = 3'(4 + $urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            if (kind == 0) begin
                b = w ? {$urandom, 32'd0} : 64'd0;
            end else if (kind == 1) begin
                a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end else if (kind == 2) begin
                b = 64'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            run_op(f3, w, a, b, ns, nv, r);
            exp_r = ref_res(f3, w, a, b);
            n_checks++;
            if (ns !== ref_stall(f3, w, a, b) || nv !== 1) begin
                n_fail++; $display("FAIL rand_timing op=%0d f3=%b w=%0d stall=%0d pulses=%0d exp=%0d 1",
                                   i, f3, w, ns, nv, ref_stall(f3, w, a, b));
            end
            n_checks++;
            if (r !== exp_r) begin
                n_fail++; $display("FAIL rand_result op=%0d f3=%b w=%0d a=%h b=%h got=%h exp=%h",
                                   i, f3, w, a, b, r, exp_r);
            end
            if ($urandom_range(0, 2) == 0) idle_cycle(s, v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_non_div();
        test_unsigned();
        test_signed();
        test_special();
        test_word();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
